opb_register_ppc2simulink: RTL and testbench

OPB_REGISTER_PPC2SIMULINK -- requirements
Module: opb_register_ppc2simulink

---
 rtl/opb_register_ppc2simulink.sv | 152 +++++++++++++++
 tb/tb_opb_register_ppc2simulink.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_ppc2simulink.sv
// opb_register_ppc2simulink
// OPB slave exposing one DATA word from the PowerPC to a Simulink-side
// consumer, with a valid/ack handshake, a sticky overrun flag and a 16-bit
// write counter in the STATUS word.
// Optional feature: define PPC2SIMULINK_READBACK_EN to make DATA readable
// over OPB; without it a DATA read returns zero but is still acknowledged.
module opb_register_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic [31:0] user_data_out,
    output logic        user_data_valid,
    input  logic        user_ack
);

    // Bus widths and family are fixed by the port list; kept for IP-XACT compatibility.
    localparam int unused_widths = C_OPB_AWIDTH + C_OPB_DWIDTH;
    localparam bit unused_family = (C_FAMILY == "virtex5");

    logic        unused_inputs;
    logic [31:0] addr_off;
    logic        in_range;
    logic        hit;

    logic        xfer_ack_reg;
    logic        busy_reg;
    logic        rnw_reg;
    logic [5:0]  offset_reg;
    logic [0:3]  be_reg;
    logic [31:0] wdata_reg;
    logic [31:0] sl_dbus_reg;

    logic [31:0] data_reg;
    logic        data_valid_reg;
    logic        overrun_reg;
    logic [15:0] wr_count_reg;

    logic [31:0] rdata;
    logic [31:0] be_mask;
    logic [31:0] data_next;
    logic        data_wr;
    logic        status_wr;

    assign unused_inputs = OPB_seqAddr;

    // Unsigned offset compare covers base <= addr <= high in one subtraction.
    assign addr_off = OPB_ABus - C_BASEADDR;
    assign in_range = (addr_off <= (C_HIGHADDR - C_BASEADDR));
    assign hit      = OPB_select && in_range && !busy_reg;

    // Writes commit at the end of the ack cycle using the values captured at the hit.
    assign data_wr   = xfer_ack_reg && !rnw_reg && (offset_reg == 6'd0);
    assign status_wr = xfer_ack_reg && !rnw_reg && (offset_reg == 6'd1);

    // Byte-lane mask: BE[0] qualifies the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_mask
            assign be_mask[31-8*gi -: 8] = {8{be_reg[gi]}};
        end
    endgenerate

    assign data_next = (data_reg & ~be_mask) | (wdata_reg & be_mask);

    // Read mux, evaluated on the live address at the moment of the hit.
    always_comb begin
        rdata = '0;
        case (OPB_ABus[24:29])
`ifdef PPC2SIMULINK_READBACK_EN
            6'd0:    rdata = data_reg;
`else
            6'd0:    rdata = '0;
`endif
            6'd1:    rdata = {data_valid_reg, overrun_reg, 14'd0, wr_count_reg};
            default: rdata = '0;
        endcase
    end

    // Bus handshake: one ack per select pulse, transfer attributes captured at the hit.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            xfer_ack_reg <= 1'b0;
            busy_reg     <= 1'b0;
            rnw_reg      <= 1'b0;
            offset_reg   <= '0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            sl_dbus_reg  <= '0;
        end else begin
            xfer_ack_reg <= hit;
            sl_dbus_reg  <= (hit && OPB_RNW) ? rdata : '0;
            if (hit) begin
                busy_reg   <= 1'b1;
                rnw_reg    <= OPB_RNW;
                offset_reg <= OPB_ABus[24:29];
                be_reg     <= OPB_BE;
                wdata_reg  <= OPB_DBus;
            end else if (!OPB_select) begin
                busy_reg   <= 1'b0;
            end
        end
    end

    // User-side registers: data, valid handshake, sticky overrun, write counter.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            wr_count_reg   <= '0;
        end else begin
            if (data_wr) begin
                data_reg       <= data_next;
                wr_count_reg   <= wr_count_reg + 16'd1;
                data_valid_reg <= 1'b1;
                if (data_valid_reg && !user_ack) begin
                    overrun_reg <= 1'b1;
                end
            end else if (user_ack) begin
                data_valid_reg <= 1'b0;
            end
            if (status_wr && be_reg[0] && wdata_reg[30]) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign Sl_xferAck      = xfer_ack_reg;
    assign Sl_DBus         = sl_dbus_reg;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;
    assign user_data_out   = data_reg;
    assign user_data_valid = data_valid_reg;

endmodule

// File: tb/tb_opb_register_ppc2simulink.sv
// Testbench for opb_register_ppc2simulink: scoreboard of expected Sl_DBus
// values per transaction plus a small register model of DATA/STATUS.
module tb_opb_register_ppc2simulink;

    logic        clk;
    logic        rst_n;
    logic [0:31] opb_abus;
    logic [0:3]  opb_be;
    logic [0:31] opb_dbus;
    logic        opb_rnw;
    logic        opb_select;
    logic        opb_seqaddr;
    logic [0:31] sl_dbus;
    logic        sl_xferack;
    logic        sl_errack;
    logic        sl_retry;
    logic        sl_toutsup;
    logic [31:0] user_data_out;
    logic        user_data_valid;
    logic        user_ack;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    // Register model
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_over;
    logic [15:0] m_count;

    opb_register_ppc2simulink dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .OPB_ABus       (opb_abus),
        .OPB_BE         (opb_be),
        .OPB_DBus       (opb_dbus),
        .OPB_RNW        (opb_rnw),
        .OPB_select     (opb_select),
        .OPB_seqAddr    (opb_seqaddr),
        .Sl_DBus        (sl_dbus),
        .Sl_xferAck     (sl_xferack),
        .Sl_errAck      (sl_errack),
        .Sl_retry       (sl_retry),
        .Sl_toutSup     (sl_toutsup),
        .user_data_out  (user_data_out),
        .user_data_valid(user_data_valid),
        .user_ack       (user_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status();
        return {m_valid, m_over, 14'd0, m_count};
    endfunction

    function automatic logic [31:0] exp_data_read();
`ifdef PPC2SIMULINK_READBACK_EN
        return m_data;
`else
        return 32'h0000_0000;
`endif
    endfunction

    task automatic model_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_count = '0;
    endtask

    // One OPB transfer; expected Sl_DBus is queued and compared at the ack.
    task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] exp_dbus,
                        input bit uack_at_commit, input string name);
        logic [31:0] exp_v;
        logic [31:0] got_d;
        bit          got;
        exp_q.push_back(exp_dbus);
        @(negedge clk);
        opb_abus   = addr;
        opb_rnw    = rnw;
        opb_be     = be;
        opb_dbus   = rnw ? 32'h0 : wdata;
        opb_select = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 16 && !got; c++) begin
            @(negedge clk);
            if (sl_xferack === 1'b1) got = 1'b1;
        end
        exp_v = exp_q.pop_front();
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_ack: no Sl_xferAck within 16 cycles, required one ack", name);
            opb_select = 1'b0;
            @(negedge clk);
            return;
        end
        got_d = sl_dbus;
        n_tests++;
        if (got_d !== exp_v) begin
            n_fail++;
            $display("FAIL %s_dbus: got %h required %h", name, got_d, exp_v);
        end
        if (uack_at_commit) user_ack = 1'b1;
        opb_select = 1'b0;
        opb_abus   = '0;
        opb_dbus   = '0;
        opb_be     = '0;
        @(negedge clk);
        user_ack = 1'b0;
        n_tests++;
        if (sl_xferack !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: Sl_xferAck got %b required 0 after ack cycle", name, sl_xferack);
        end
        $display("[TB] %s addr=%h rnw=%0d be=%b dbus=%h", name, addr, rnw, be, got_d);
    endtask

    task automatic data_write(input logic [31:0] d, input logic [3:0] be, input bit uack);
        xfer(32'h0, 1'b0, be, d, 32'h0, uack, "data_wr");
        if (m_valid && !uack) m_over = 1'b1;
        m_valid = 1'b1;
        m_count = m_count + 16'd1;
        for (int b = 0; b < 4; b++)
            if (be[3-b]) m_data[31-8*b -: 8] = d[31-8*b -: 8];
        n_tests++;
        if (user_data_out !== m_data) begin
            n_fail++;
            $display("FAIL data_wr_out: user_data_out got %h required %h", user_data_out, m_data);
        end
        n_tests++;
        if (user_data_valid !== m_valid) begin
            n_fail++;
            $display("FAIL data_wr_valid: user_data_valid got %b required %b", user_data_valid, m_valid);
        end
    endtask

    task automatic status_read();
        xfer(32'h4, 1'b1, 4'hF, 32'h0, exp_status(), 1'b0, "status_rd");
    endtask

    task automatic status_write(input logic [31:0] d, input logic [3:0] be);
        xfer(32'h4, 1'b0, be, d, 32'h0, 1'b0, "status_wr");
        if (be[3] && d[30]) m_over = 1'b0;
    endtask

    task automatic data_read();
        xfer(32'h0, 1'b1, 4'hF, 32'h0, exp_data_read(), 1'b0, "data_rd");
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        opb_select = 1'b1;
        opb_abus   = 32'h0;
        opb_rnw    = 1'b0;
        opb_dbus   = 32'hFFFF_FFFF;
        opb_be     = 4'hF;
        repeat (3) @(negedge clk);
        n_tests++;
        if (sl_xferack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0", sl_xferack); end
        n_tests++;
        if (sl_dbus !== 32'h0) begin n_fail++; $display("FAIL reset_dbus: got %h required 0", sl_dbus); end
        n_tests++;
        if (user_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h required 0", user_data_out); end
        n_tests++;
        if (user_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", user_data_valid); end
        opb_select = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset released");
        status_read();
        data_read();
    endtask

    task automatic test_data_write();
        data_write(32'hDEAD_BEEF, 4'b1111, 1'b0);
        status_read();
        data_read();
    endtask

    task automatic test_byte_enable();
        data_write(32'h1122_3344, 4'b0101, 1'b0);
        n_tests++;
        if (user_data_out !== 32'hDE22_BE44) begin
            n_fail++;
            $display("FAIL byte_enable: user_data_out got %h required DE22BE44", user_data_out);
        end
        data_read();
    endtask

    task automatic test_overrun();
        status_read();
        n_tests++;
        if (exp_status() !== 32'hC000_0002) begin
            n_fail++;
            $display("FAIL overrun_model: model status %h required C0000002", exp_status());
        end
        status_write(32'hBFFF_FFFF, 4'b1111);
        status_read();
        status_write(32'h4000_0000, 4'b0111);
        status_read();
        status_write(32'h4000_0000, 4'b1111);
        status_read();
    endtask

    task automatic test_user_ack();
        @(negedge clk);
        user_ack = 1'b1;
        @(negedge clk);
        user_ack = 1'b0;
        m_valid = 1'b0;
        n_tests++;
        if (user_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL user_ack_clear: user_data_valid got %b required 0", user_data_valid);
        end
        $display("[TB] user_ack pulse");
        data_write(32'hCAFE_F00D, 4'hF, 1'b0);
        data_write(32'h0BAD_F00D, 4'hF, 1'b1);
        status_read();
    endtask

    task automatic test_select_hold();
        int acks;
        acks = 0;
        @(negedge clk);
        opb_abus   = 32'h14;
        opb_rnw    = 1'b1;
        opb_be     = 4'hF;
        opb_select = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (sl_xferack === 1'b1) acks++;
        end
        opb_select = 1'b0;
        @(negedge clk);
        if (sl_xferack === 1'b1) acks++;
        @(negedge clk);
        n_tests++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL select_hold: ack pulses got %0d required 1", acks);
        end
        $display("[TB] select_hold acks=%0d", acks);
        xfer(32'h14, 1'b0, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, "word5_wr");
        xfer(32'hFC, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0, "word63_rd");
        status_read();
        data_read();
    endtask

    task automatic test_out_of_range();
        int acks;
        acks = 0;
        @(negedge clk);
        opb_abus   = 32'h100;
        opb_rnw    = 1'b1;
        opb_select = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (sl_xferack === 1'b1) acks++;
        end
        opb_select = 1'b0;
        opb_abus   = '0;
        @(negedge clk);
        n_tests++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL out_of_range: ack pulses got %0d required 0", acks);
        end
        $display("[TB] out_of_range acks=%0d", acks);
    endtask

    task automatic test_reset_abort();
        int acks;
        acks = 0;
        @(negedge clk);
        opb_abus   = 32'h0;
        opb_rnw    = 1'b0;
        opb_be     = 4'hF;
        opb_dbus   = 32'h1234_5678;
        opb_select = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (sl_xferack === 1'b1) acks++;
        end
        n_tests++;
        if (user_data_out !== 32'h0) begin n_fail++; $display("FAIL abort_data: got %h required 0", user_data_out); end
        n_tests++;
        if (user_data_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b required 0", user_data_valid); end
        n_tests++;
        if (sl_dbus !== 32'h0) begin n_fail++; $display("FAIL abort_dbus: got %h required 0", sl_dbus); end
        opb_select = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (sl_xferack === 1'b1) acks++;
        end
        n_tests++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL abort_ack: ack pulses got %0d required 0", acks);
        end
        n_tests++;
        if (user_data_out !== 32'h0) begin n_fail++; $display("FAIL abort_noupdate: got %h required 0", user_data_out); end
        model_reset();
        $display("[TB] reset_abort acks=%0d", acks);
        status_read();
    endtask

    task automatic test_wrap();
        int acks;
        acks = 0;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            opb_abus   = 32'h0;
            opb_rnw    = 1'b0;
            opb_be     = 4'hF;
            opb_dbus   = 32'hDEAD_BEEF;
            opb_select = 1'b1;
            @(negedge clk);
            if (sl_xferack === 1'b1) acks++;
            opb_select = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if (acks != 65535) begin
            n_fail++;
            $display("FAIL wrap_acks: got %0d required 65535", acks);
        end
        m_count = m_count + 16'hFFFF;
        m_valid = 1'b1;
        m_over  = 1'b1;
        m_data  = 32'hDEAD_BEEF;
        $display("[TB] bulk data writes=%0d", acks);
        status_read();
        data_write(32'hDEAD_BEEF, 4'hF, 1'b0);
        n_tests++;
        if (m_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_model: model count %h required 0000", m_count);
        end
        status_read();
        data_read();
    endtask

    initial begin
        opb_abus    = '0;
        opb_be      = '0;
        opb_dbus    = '0;
        opb_rnw     = 1'b0;
        opb_select  = 1'b0;
        opb_seqaddr = 1'b0;
        user_ack    = 1'b0;
        rst_n       = 1'b1;
        test_reset();
        test_data_write();
        test_byte_enable();
        test_overrun();
        test_user_ack();
        test_select_hold();
        test_out_of_range();
        test_reset_abort();
        test_wrap();
        n_tests++;
        if ((sl_errack | sl_retry | sl_toutsup) !== 1'b0) begin
            n_fail++;
            $display("FAIL tied_outputs: errAck/retry/toutSup got %b%b%b required 000", sl_errack, sl_retry, sl_toutsup);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
